// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: synchronizer, prescaled debounce, edge pulses
// and sticky per-bit edge interrupt status.
module gpio_in_cond #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] gpio_in_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_status_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] h0;
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] status;
  logic [DIV_W-1:0] cnt;

  logic             tick;
  logic [WIDTH-1:0] agree;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] set_d;

  // >= so a lowered divider ticks at once instead of wrapping through
  assign tick = (cnt >= div_i);

  always_comb begin
    agree  = ~(s2 ^ h0) & ~(s2 ^ h1);
    rise_d = {WIDTH{tick}} & agree & s2 & ~stable;
    fall_d = {WIDTH{tick}} & agree & ~s2 & stable;
    set_d  = (rise_d & rise_en_i) | (fall_d & fall_en_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0     <= '0;
      h1     <= '0;
      stable <= '0;
    end else if (tick) begin
      h0     <= s2;
      h1     <= h0;
      stable <= (stable & ~fall_d) | rise_d;
    end
  end

  // set beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
      status <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      status <= (status & ~irq_clr_i) | set_d;
    end
  end

  assign gpio_in_o    = stable;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign irq_status_o = status;
  assign irq_o        = |status;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: vector table plus edge-pulse scoreboard
// and hand sequences for latency, glitch, prescaler, race and reset.
module tb_gpio_in_cond;

  logic        clk;
  logic        rst_n;
  logic [31:0] pad;
  logic [15:0] div;
  logic [31:0] ren;
  logic [31:0] fen;
  logic [31:0] clr;
  logic [31:0] gpio_in;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] st;
  logic        irq;

  gpio_in_cond #(.WIDTH(32), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_i        (pad),
    .div_i        (div),
    .rise_en_i    (ren),
    .fall_en_i    (fen),
    .irq_clr_i    (clr),
    .gpio_in_o    (gpio_in),
    .rise_o       (rise),
    .fall_o       (fall),
    .irq_status_o (st),
    .irq_o        (irq)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] f;
  } ev_t;

  typedef struct {
    logic [31:0] pad;
    logic [15:0] div;
    logic [31:0] ren;
    logic [31:0] fen;
    int          wait_n;
    logic [31:0] exp_in;
    logic [31:0] exp_st;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [31:0] f);
    ev_t e;
    e.r = r;
    e.f = f;
    if ((r | f) != 0) sb.push_back(e);
  endtask

  // every pulse observed must match the oldest expected event
  always @(posedge clk) begin : mon
    ev_t e;
    #1;
    if ((rise | fall) != 0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got rise=%h fall=%h want none",
                 rise, fall);
      end else begin
        e = sb.pop_front();
        check("sb_rise", rise, e.r);
        check("sb_fall", fall, e.f);
      end
    end
  end

  initial begin
    int n;
    vecs[0] = '{32'hA5A5_A5A5, 16'd0, 32'hFFFF_FFFF, 32'h0,
                8, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[1] = '{32'h5A5A_5A5A, 16'd0, 32'h0, 32'hFFFF_FFFF,
                8, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
    vecs[2] = '{32'hFFFF_0000, 16'd0, 32'h0000_FFFF, 32'hFFFF_0000,
                8, 32'hFFFF_0000, 32'h0};
    vecs[3] = '{32'h0000_FFFF, 16'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                20, 32'h0000_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0, 16'd0, 32'h0, 32'h0,
                8, 32'h0, 32'h0};

    rst_n = 1'b0;
    pad   = '0;
    div   = '0;
    ren   = '0;
    fen   = '0;
    clr   = '0;
    prev  = '0;

    step(2);
    check("rst_gpio_in", gpio_in, 32'h0);
    check("rst_status", st, 32'h0);
    check("rst_pulses", rise | fall, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // minimum latency at div 0
    rst_n = 1'b1;
    ren   = 32'h1;
    pad   = 32'h1;
    push(32'h1, 32'h0);
    step(4);
    check("lat_early", gpio_in, 32'h0);
    step(1);
    check("lat_gpio_in", gpio_in, 32'h1);
    check("lat_rise", rise, 32'h1);
    check("lat_irq", {31'h0, irq}, 32'h1);
    step(1);
    check("lat_rise_gone", rise, 32'h0);
    clr = 32'hFFFF_FFFF;
    step(1);
    clr = '0;
    check("lat_clr", st, 32'h0);
    ren = '0;
    pad = '0;
    push(32'h0, 32'h1);
    step(8);

    // two-cycle glitch on bit 3
    pad = 32'h8;
    step(2);
    pad = '0;
    step(10);
    check("glitch_gpio_in", gpio_in, 32'h0);
    check("glitch_status", st, 32'h0);

    for (int i = 0; i < 5; i++) begin
      pad = vecs[i].pad;
      div = vecs[i].div;
      ren = vecs[i].ren;
      fen = vecs[i].fen;
      push(~prev & vecs[i].pad, prev & ~vecs[i].pad);
      prev = vecs[i].pad;
      step(vecs[i].wait_n);
      check($sformatf("vec%0d_in", i), gpio_in, vecs[i].exp_in);
      check($sformatf("vec%0d_st", i), st, vecs[i].exp_st);
      check($sformatf("vec%0d_irq", i), {31'h0, irq},
            {31'h0, vecs[i].exp_st != 0});
      clr = 32'hFFFF_FFFF;
      step(1);
      clr = '0;
    end

    // prescaler at div 3
    div = 16'd3;
    pad = 32'h80;
    push(32'h80, 32'h0);
    n = 0;
    while (n < 30 && gpio_in[7] !== 1'b1) begin
      step(1);
      n++;
    end
    total++;
    if (n < 10 || n > 14) begin
      bad++;
      $display("FAIL presc_latency: got %0d want 10..14", n);
    end
    step(20);
    check("presc_hold", gpio_in, 32'h80);
    pad = '0;
    push(32'h0, 32'h80);
    step(20);
    check("presc_back", gpio_in, 32'h0);
    div = '0;
    step(4);

    // set/clear race on bit 5
    ren = 32'h20;
    fen = 32'h20;
    pad = 32'h20;
    push(32'h20, 32'h0);
    step(8);
    check("race_pre", st, 32'h20);
    pad = '0;
    push(32'h0, 32'h20);
    step(4);
    clr = 32'h20;
    step(1);
    clr = '0;
    check("race_status", st, 32'h20);
    check("race_fall", fall, 32'h20);
    ren = '0;
    fen = '0;
    step(2);
    check("en_off_keeps", st, 32'h20);
    clr = 32'h20;
    step(1);
    clr = '0;
    check("lone_clr", st, 32'h0);
    check("lone_clr_irq", {31'h0, irq}, 32'h0);

    // reset in the middle of qualification
    ren = 32'hFFFF_FFFF;
    pad = 32'hFFFF_FFFF;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in", gpio_in, 32'h0);
    check("mid_rst_st", st, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    step(2);
    rst_n = 1'b1;
    push(32'hFFFF_FFFF, 32'h0);
    step(4);
    check("post_rst_early", gpio_in, 32'h0);
    step(1);
    check("post_rst_in", gpio_in, 32'hFFFF_FFFF);
    check("post_rst_st", st, 32'hFFFF_FFFF);
    step(3);

    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, pin count; DIV_W, default 16, prescaler width.
REQ-002 SHALL have ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- pad_i  input  WIDTH  raw asynchronous pin levels.
- div_i  input  DIV_W  sample-tick period minus one; quasi-static.
- rise_en_i  input  WIDTH  per-bit rising-edge interrupt enable.
- fall_en_i  input  WIDTH  per-bit falling-edge interrupt enable.
- irq_clr_i  input  WIDTH  per-bit status clear; one-cycle pulse, write-1-to-clear.
- gpio_in_o  output  WIDTH  debounced level; drives gpio_in of the Wishbone GPIO slave.
- rise_o  output  WIDTH  one-cycle pulse per debounced 0->1.
- fall_o  output  WIDTH  one-cycle pulse per debounced 1->0.
- irq_status_o  output  WIDTH  sticky edge-event flags.
- irq_o  output  1  OR of irq_status_o.

Function
REQ-003 SHALL pass each pad_i bit through a 2-flop synchronizer (s1, s2); the block uses only s2.
REQ-004 SHALL run one shared prescaler counter cnt (DIV_W bits).
- tick = (cnt >= div_i).
- On tick, cnt <= 0; otherwise cnt <= cnt+1.
- div_i = 0 gives a tick every cycle.
- div_i lowered below cnt mid-count gives a tick on the next cycle; there is no counter wrap-through.
REQ-005 SHALL keep a per-bit 2-deep sample history hist[1:0]. On tick, hist <= {hist[0], s2}. No tick means no change.
REQ-006 SHALL update the per-bit stable register only on a tick, and only when all three of s2, hist[0] and hist[1] are equal and differ from stable; stable then takes s2. Three consecutive equal tick samples are required, and shorter glitches are discarded.
REQ-007 SHALL drive gpio_in_o directly from stable (registered, no combinational path from pad_i).
REQ-008 SHALL assert rise_o[i] (fall_o[i]) for exactly one clk, registered, in the same cycle the new stable value 1 (0) first appears on gpio_in_o.
REQ-009 SHALL set irq_status_o[i] on (rise & rise_en_i[i]) | (fall & fall_en_i[i]), evaluated in the cycle the edge is detected; it becomes visible together with rise_o/fall_o.
REQ-010 SHALL clear irq_status_o[i] on irq_clr_i[i]=1. When set and clear occur in the same cycle, set SHALL win.
REQ-011 SHALL drive irq_o combinationally as OR-reduce of irq_status_o; it has no extra latency.
REQ-012 SHALL not let enable changes retroactively set or clear status. Clearing an enable leaves any already-set status bit intact.
REQ-013 SHALL process all bits independently and in parallel. Simultaneous edges on several bits each produce their own pulse and status bit.
REQ-014 SHALL have a minimum latency of 5 clk at div_i=0, from a pad change set up before edge E to gpio_in_o updated after edge E+4.
REQ-015 SHALL have a general latency of at most 2 + 3*(div_i+1) clk.

Reset
REQ-016 While rst_n=0 SHALL asynchronously force to 0: s1, s2, hist, stable, cnt, rise_o, fall_o, irq_status_o; so gpio_in_o=0 and irq_o=0.
REQ-017 SHALL resume on the first clk edge after rst_n rises, with cnt starting from 0.
REQ-018 SHALL, on reset mid-debounce, discard partial history. A pad held high through reset is re-qualified from scratch and produces a rise_o pulse.

Verification
REQ-019 Latency: div_i=0, pad_i[0] 0->1 before edge 1 -> gpio_in_o[0]=1 and rise_o[0] pulse after edge 5; rise_en_i[0]=1 -> irq_o=1 after edge 5.
REQ-020 Glitch reject: div_i=0, pad_i[3] high for 2 cycles only -> gpio_in_o[3] stays 0, no rise_o, no fall_o.
REQ-021 Prescaler: div_i=3, pad_i[7] 0->1 held -> tick every 4 clk; gpio_in_o[7] rises between 10 and 14 clk after the change; exactly one rise_o[7] pulse.
REQ-022 Status clear race: irq_status_o[5]=1, irq_clr_i[5] pulsed in the same cycle a new enabled fall on bit 5 is detected -> irq_status_o[5] stays 1; a later lone clear -> 0, irq_o=0.
REQ-023 Multi-bit: pad_i 0x0000_0000 -> 0xA5A5_A5A5, rise_en_i=0xFFFF_FFFF -> rise_o=0xA5A5_A5A5 for one cycle, irq_status_o=0xA5A5_A5A5.
REQ-024 Reset mid-operation: assert rst_n=0 during qualification, with pad_i=0xFFFF_FFFF -> all outputs 0 immediately; after release, gpio_in_o=0xFFFF_FFFF after 5 clk (div_i=0).
